// File: rtl/layer_compositor_pkg.sv
// Shared constants for the layer compositor: pixel width, RGB222 colours, layer indices.
package layer_compositor_pkg;

    localparam int unsigned PIX_W = 6;

    localparam logic [PIX_W-1:0] BLACK       = 6'b000000;
    localparam logic [PIX_W-1:0] WHITE       = 6'b111111;
    localparam logic [PIX_W-1:0] SHOT_COLOUR = 6'b101010;

    localparam int unsigned DUCK  = 0;
    localparam int unsigned GUN   = 1;
    localparam int unsigned SHOT1 = 2;
    localparam int unsigned SHOT2 = 3;
    localparam int unsigned SHOT3 = 4;
    localparam int unsigned SHOT4 = 5;
    localparam int unsigned SHOT5 = 6;
    localparam int unsigned SHOT6 = 7;
    localparam int unsigned SHOT7 = 8;
    localparam int unsigned SHOT8 = 9;

    // Index width for n layers; a single layer still gets a 1-bit index.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_compositor_prio_encoder.sv
// Fixed-priority encoder: lowest set request bit wins.
module prio_encoder
    import layer_compositor_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic [WIDTH-1:0]        req,
    output logic                    found_c,
    output logic [idx_w(WIDTH)-1:0] idx_c
);

    localparam int unsigned IDX_W = idx_w(WIDTH);

    // Scan from the top down so the lowest-index request is assigned last.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_c = 1'b1;
                idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite/layer compositor with frame-shadowed enables and flashing layers.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int unsigned            NUM_LAYERS = 12,
    parameter int unsigned            DATA_W     = PIX_W,
    parameter int unsigned            FLASH_BIT  = 4,
    parameter logic [NUM_LAYERS-1:0]  EN_RESET   = '1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid_in,
    input  logic [NUM_LAYERS-1:0]         layer_hit,
    input  logic [NUM_LAYERS*DATA_W-1:0]  layer_data,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_en_next,
    input  logic [NUM_LAYERS-1:0]         flash_mask,
    output logic [DATA_W-1:0]             data,
    output logic                          draw,
    output logic                          pix_valid_out,
    output logic [idx_w(NUM_LAYERS)-1:0]  hit_index
);

    localparam int unsigned IDX_W = idx_w(NUM_LAYERS);
    localparam int unsigned CNT_W = 8;

    logic [NUM_LAYERS-1:0]        en_active;
    logic [CNT_W-1:0]             frame_cnt;
    logic                         flash_phase_c;
    logic [NUM_LAYERS-1:0]        elig_c;

    logic [NUM_LAYERS-1:0]        s1_elig;
    logic [NUM_LAYERS*DATA_W-1:0] s1_data;
    logic                         s1_valid;

    logic                         found_c;
    logic [IDX_W-1:0]             win_idx_c;
    logic [DATA_W-1:0]            sel_data_c;

    assign flash_phase_c = frame_cnt[FLASH_BIT];

    // Stage-1 eligibility uses pre-frame_start enables and flash phase.
    assign elig_c = layer_hit & en_active
                  & ~(flash_mask & {NUM_LAYERS{flash_phase_c}})
                  & {NUM_LAYERS{pix_valid_in}};

    // Frame-rate state: shadowed enables and wrapping frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_active <= EN_RESET;
            frame_cnt <= '0;
        end else if (frame_start) begin
            en_active <= layer_en_next;
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Stage 1: register eligibility, colours and pixel qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_elig  <= '0;
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_elig  <= elig_c;
            s1_data  <= layer_data;
            s1_valid <= pix_valid_in;
        end
    end

    prio_encoder #(
        .WIDTH (NUM_LAYERS)
    ) u_prio (
        .req     (s1_elig),
        .found_c (found_c),
        .idx_c   (win_idx_c)
    );

    // Colour mux for the winning layer.
    always_comb begin
        sel_data_c = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (win_idx_c == IDX_W'(k)) begin
                sel_data_c = s1_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Stage 2: register composited output; colour and index hold when nothing wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data          <= '0;
            draw          <= 1'b0;
            hit_index     <= '0;
            pix_valid_out <= 1'b0;
        end else begin
            draw          <= found_c;
            pix_valid_out <= s1_valid;
            if (found_c) begin
                data      <= sel_data_c;
                hit_index <= win_idx_c;
            end
        end
    end

endmodule
